// File: rtl/wb_arb2.sv
// rtl/wb_arb2.sv - two-master Wishbone arbiter with alternating priority and bus-stall timeout
//
// Ports:
//   i_clk, i_rst            clock; asynchronous active-high reset
//   mN_cyc/stb/we/adr/      master N request side (N = 0, 1)
//   mN_o_dat/sel
//   mN_i_dat                read data to master N (always wb_i_dat)
//   mN_ack/mN_err           termination to master N (only the owner sees it)
//   wb_cyc/stb/we/adr/      shared-bus request side, follows the owner while BUSY
//   wb_o_dat/sel
//   wb_i_dat/ack/err        shared-bus response
//   o_grant                 one-hot owner, 2'b00 while IDLE
//
// TIMEOUT: stall cycles tolerated before the owner is aborted with an error; 0 disables.

`ifndef WB_ADDR_W
`define WB_ADDR_W 16
`endif

module wb_arb2 #(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  m0_cyc,
    input  logic                  m0_stb,
    input  logic                  m0_we,
    input  logic [`WB_ADDR_W-1:0] m0_adr,
    input  logic [15:0]           m0_o_dat,
    input  logic [1:0]            m0_sel,
    output logic [15:0]           m0_i_dat,
    output logic                  m0_ack,
    output logic                  m0_err,
    input  logic                  m1_cyc,
    input  logic                  m1_stb,
    input  logic                  m1_we,
    input  logic [`WB_ADDR_W-1:0] m1_adr,
    input  logic [15:0]           m1_o_dat,
    input  logic [1:0]            m1_sel,
    output logic [15:0]           m1_i_dat,
    output logic                  m1_ack,
    output logic                  m1_err,
    output logic                  wb_cyc,
    output logic                  wb_stb,
    output logic                  wb_we,
    output logic [`WB_ADDR_W-1:0] wb_adr,
    output logic [15:0]           wb_o_dat,
    output logic [1:0]            wb_sel,
    input  logic [15:0]           wb_i_dat,
    input  logic                  wb_ack,
    input  logic                  wb_err,
    output logic [1:0]            o_grant
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_ABORT = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic       g_q, g_d;       // owner index
    logic       lp_q, lp_d;     // last owner, loses the next tie
    logic [7:0] cnt_q, cnt_d;   // stall counter

    // Signals of the master selected by g_q.
    logic                  mg_cyc;
    logic                  mg_stb;
    logic                  mg_we;
    logic [`WB_ADDR_W-1:0] mg_adr;
    logic [15:0]           mg_o_dat;
    logic [1:0]            mg_sel;

    logic resp_ack;
    logic resp_err;

    always_comb begin
        mg_cyc   = g_q ? m1_cyc   : m0_cyc;
        mg_stb   = g_q ? m1_stb   : m0_stb;
        mg_we    = g_q ? m1_we    : m0_we;
        mg_adr   = g_q ? m1_adr   : m0_adr;
        mg_o_dat = g_q ? m1_o_dat : m0_o_dat;
        mg_sel   = g_q ? m1_sel   : m0_sel;
    end

    // Read data needs no steering: only the owner gets an ack to qualify it.
    assign m0_i_dat = wb_i_dat;
    assign m1_i_dat = wb_i_dat;

    always_comb begin
        state_d  = state_q;
        g_d      = g_q;
        lp_d     = lp_q;
        cnt_d    = 8'd0;
        wb_cyc   = 1'b0;
        wb_stb   = 1'b0;
        wb_we    = 1'b0;
        wb_adr   = '0;
        wb_o_dat = 16'd0;
        wb_sel   = 2'b00;
        resp_ack = 1'b0;
        resp_err = 1'b0;
        o_grant  = 2'b00;

        case (state_q)
            S_IDLE: begin
                if (m0_cyc || m1_cyc) begin
                    // On a tie the master that did not own the bus last wins.
                    if (m0_cyc && m1_cyc) begin
                        g_d = ~lp_q;
                    end else begin
                        g_d = m1_cyc;
                    end
                    lp_d    = g_d;
                    state_d = S_BUSY;
                end
            end

            S_BUSY: begin
                o_grant  = g_q ? 2'b10 : 2'b01;
                wb_cyc   = mg_cyc;
                wb_stb   = mg_stb;
                wb_we    = mg_we;
                wb_adr   = mg_adr;
                wb_o_dat = mg_o_dat;
                wb_sel   = mg_sel;
                resp_ack = wb_ack;
                resp_err = wb_err;

                if (!mg_cyc) begin
                    // Owner gave up the bus; a pending stall is simply dropped.
                    state_d = S_IDLE;
                end else if ((TIMEOUT != 8'd0) && (cnt_q == TIMEOUT) && !wb_ack && !wb_err) begin
                    resp_err = 1'b1;
                    state_d  = S_ABORT;
                end

                if (mg_stb && !wb_ack && !wb_err) begin
                    cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                end
            end

            S_ABORT: begin
                // Bus released; wait for the aborted master to end its cycle.
                o_grant = g_q ? 2'b10 : 2'b01;
                if (!mg_cyc) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        m0_ack = resp_ack & ~g_q;
        m1_ack = resp_ack &  g_q;
        m0_err = resp_err & ~g_q;
        m1_err = resp_err &  g_q;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            g_q     <= 1'b0;
            lp_q    <= 1'b1;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            lp_q    <= lp_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_wb_arb2.sv
// tb/tb_wb_arb2.sv - self-checking bench for wb_arb2

`ifndef WB_ADDR_W
`define WB_ADDR_W 16
`endif

module tb_wb_arb2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  m0_cyc, m0_stb, m0_we;
    logic [`WB_ADDR_W-1:0] m0_adr;
    logic [15:0]           m0_o_dat;
    logic [1:0]            m0_sel;
    logic [15:0]           m0_i_dat;
    logic                  m0_ack, m0_err;
    logic                  m1_cyc, m1_stb, m1_we;
    logic [`WB_ADDR_W-1:0] m1_adr;
    logic [15:0]           m1_o_dat;
    logic [1:0]            m1_sel;
    logic [15:0]           m1_i_dat;
    logic                  m1_ack, m1_err;
    logic                  wb_cyc, wb_stb, wb_we;
    logic [`WB_ADDR_W-1:0] wb_adr;
    logic [15:0]           wb_o_dat;
    logic [1:0]            wb_sel;
    logic [15:0]           wb_i_dat;
    logic                  wb_ack, wb_err;
    logic [1:0]            o_grant;

    always #5 clk = ~clk;

    wb_arb2 #(.TIMEOUT(8'd4)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .m0_cyc   (m0_cyc),
        .m0_stb   (m0_stb),
        .m0_we    (m0_we),
        .m0_adr   (m0_adr),
        .m0_o_dat (m0_o_dat),
        .m0_sel   (m0_sel),
        .m0_i_dat (m0_i_dat),
        .m0_ack   (m0_ack),
        .m0_err   (m0_err),
        .m1_cyc   (m1_cyc),
        .m1_stb   (m1_stb),
        .m1_we    (m1_we),
        .m1_adr   (m1_adr),
        .m1_o_dat (m1_o_dat),
        .m1_sel   (m1_sel),
        .m1_i_dat (m1_i_dat),
        .m1_ack   (m1_ack),
        .m1_err   (m1_err),
        .wb_cyc   (wb_cyc),
        .wb_stb   (wb_stb),
        .wb_we    (wb_we),
        .wb_adr   (wb_adr),
        .wb_o_dat (wb_o_dat),
        .wb_sel   (wb_sel),
        .wb_i_dat (wb_i_dat),
        .wb_ack   (wb_ack),
        .wb_err   (wb_err),
        .o_grant  (o_grant)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic        mst;
        logic [15:0] dat;
    } exp_t;

    exp_t exp_q[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Slave answers with an ack this cycle; the owner expected to see it is queued.
    task automatic slave_ack(input logic mst, input logic [15:0] dat);
        exp_t e;
        e.mst    = mst;
        e.dat    = dat;
        wb_i_dat = dat;
        wb_ack   = 1'b1;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (m0_ack || m1_ack) begin
            if (exp_q.size() == 0) begin
                check_eq("sb_unexpected_ack", {30'd0, m1_ack, m0_ack}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("sb_owner", {30'd0, m1_ack, m0_ack}, e.mst ? 32'd2 : 32'd1);
                check_eq("sb_rdata", e.mst ? m1_i_dat : m0_i_dat, {16'd0, e.dat});
            end
        end
    end

    initial begin
        logic [15:0] d;
        rst = 1'b1;
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_o_dat = 0; m0_sel = 0;
        m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0; m1_o_dat = 0; m1_sel = 0;
        wb_i_dat = 16'h1234; wb_ack = 0; wb_err = 0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_grant", o_grant, 0);
        check_eq("rst_wb_ctl", {wb_cyc, wb_stb, wb_we}, 0);
        check_eq("rst_wb_adr", wb_adr, 0);
        check_eq("rst_resp", {m0_ack, m1_ack, m0_err, m1_err}, 0);
        check_eq("rst_m0_dat", m0_i_dat, 16'h1234);
        check_eq("rst_m1_dat", m1_i_dat, 16'h1234);
        step();
        rst = 1'b0;

        // Simultaneous request after reset: m0 first, m1 after one idle cycle.
        m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_adr = 16'h0100; m0_o_dat = 16'hA5A5; m0_sel = 2'b11;
        m1_cyc = 1; m1_stb = 1; m1_we = 0; m1_adr = 16'h0200; m1_o_dat = 16'h5A5A; m1_sel = 2'b01;
        @(negedge clk);
        check_eq("idle_grant", o_grant, 0);
        check_eq("idle_wb_cyc", wb_cyc, 0);
        step();
        @(negedge clk);
        check_eq("tie_grant", o_grant, 2'b01);
        check_eq("busy_adr", wb_adr, 16'h0100);
        check_eq("busy_wdat", wb_o_dat, 16'hA5A5);
        check_eq("busy_we_sel", {wb_cyc, wb_we, wb_sel}, 4'b1111);
        step();
        slave_ack(1'b0, 16'h0001);
        @(negedge clk);
        step();
        wb_ack = 0; m0_cyc = 0; m0_stb = 0;
        @(negedge clk);
        check_eq("drop_grant", o_grant, 2'b01);
        check_eq("drop_wb_cyc", wb_cyc, 0);
        step();
        @(negedge clk);
        check_eq("gap_grant", o_grant, 0);
        step();
        @(negedge clk);
        check_eq("m1_grant", o_grant, 2'b10);
        check_eq("m1_adr", wb_adr, 16'h0200);
        check_eq("m1_we_sel", {wb_we, wb_sel}, 3'b001);

        // m1 keeps the bus over three transfers while m0 waits.
        step();
        m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_adr = 16'h0040;
        for (int i = 0; i < 3; i++) begin
            d = 16'hC000 + 16'(i);
            slave_ack(1'b1, d);
            @(negedge clk);
            check_eq("hold_grant", o_grant, 2'b10);
            check_eq("hold_m0_resp", {m0_ack, m0_err}, 0);
            step();
        end
        wb_ack = 0; m1_cyc = 0; m1_stb = 0;
        @(negedge clk);
        check_eq("hold_end_grant", o_grant, 2'b10);
        step();
        @(negedge clk);
        check_eq("release_gap", o_grant, 0);
        step();
        @(negedge clk);
        check_eq("m0_regrant", o_grant, 2'b01);

        // Read from 0x0040 returning 0xBEEF, then an error routed to the owner.
        check_eq("read_adr", wb_adr, 16'h0040);
        check_eq("read_we", wb_we, 0);
        step();
        slave_ack(1'b0, 16'hBEEF);
        @(negedge clk);
        check_eq("read_m1_ack", m1_ack, 0);
        check_eq("read_m0_dat", m0_i_dat, 16'hBEEF);
        step();
        wb_ack = 0; wb_err = 1;
        @(negedge clk);
        check_eq("err_route", {m1_err, m0_err}, 2'b01);
        step();
        wb_err = 0; m0_cyc = 0; m0_stb = 0;
        step();

        // Slave never answers: error on the fifth stall cycle, then ABORT.
        m0_cyc = 1; m0_stb = 1; m0_adr = 16'h0300;
        step();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("tmo_err", m0_err, (i == 4) ? 32'd1 : 32'd0);
            step();
        end
        @(negedge clk);
        check_eq("abort_bus", {wb_cyc, wb_stb}, 0);
        check_eq("abort_grant", o_grant, 2'b01);
        check_eq("abort_resp", {m0_err, m0_ack}, 0);
        step();
        @(negedge clk);
        check_eq("abort_hold", {o_grant, m0_err}, 3'b010);
        step();
        m0_cyc = 0; m0_stb = 0;
        step();
        @(negedge clk);
        check_eq("abort_idle", o_grant, 0);

        // Ack on the timeout cycle wins over the timeout.
        step();
        m0_cyc = 1; m0_stb = 1;
        step();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("stall_no_err", m0_err, 0);
            step();
        end
        slave_ack(1'b0, 16'h4444);
        @(negedge clk);
        check_eq("tmo_ack_err", m0_err, 0);
        check_eq("tmo_ack_ack", m0_ack, 1);
        step();
        wb_ack = 0;
        @(negedge clk);
        check_eq("tmo_stay_grant", o_grant, 2'b01);
        check_eq("tmo_stay_cyc", wb_cyc, 1);

        // Reset during m0 ownership: bus drops at once; tie afterwards goes to m0.
        m1_cyc = 1; m1_stb = 1;
        step();
        rst = 1'b1; wb_ack = 1; wb_err = 1;
        #1;
        check_eq("rst_async_bus", {wb_cyc, wb_stb}, 0);
        check_eq("rst_async_grant", o_grant, 0);
        check_eq("rst_async_resp", {m0_ack, m1_ack, m0_err, m1_err}, 0);
        @(negedge clk);
        step();
        wb_ack = 0; wb_err = 0; rst = 1'b0;
        step();
        @(negedge clk);
        check_eq("post_rst_grant", o_grant, 2'b01);

        m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
        step();
        step();
        check_eq("sb_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_arb2.md
WB_ARB2 -- requirements
Module: wb_arb2

Interface
REQ-001 SHALL have parameter TIMEOUT, default 8'd255, meaning bus-stall cycles before abort; 0 disables timeout.
REQ-002 SHALL have port i_clk  input  1  single clock for all state.
REQ-003 SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports m0_cyc / m1_cyc  input  1  master N bus cycle request.
REQ-005 SHALL have ports m0_stb / m1_stb  input  1  master N strobe.
REQ-006 SHALL have ports m0_we / m1_we  input  1  master N write enable.
REQ-007 SHALL have ports m0_adr / m1_adr  input  `WB_ADDR_W  master N address.
REQ-008 SHALL have ports m0_o_dat / m1_o_dat  input  16  master N write data.
REQ-009 SHALL have ports m0_sel / m1_sel  input  2  master N byte select.
REQ-010 SHALL have ports m0_i_dat / m1_i_dat  output  16  read data to master N.
REQ-011 SHALL have ports m0_ack / m1_ack and m0_err / m1_err  output  1  termination to master N.
REQ-012 SHALL have ports wb_cyc, wb_stb, wb_we  output  1  shared-bus control.
REQ-013 SHALL have ports wb_adr `WB_ADDR_W, wb_o_dat 16, wb_sel 2  output  shared-bus address, data, select.
REQ-014 SHALL have ports wb_i_dat 16, wb_ack 1, wb_err 1  input  shared-bus response.
REQ-015 SHALL have port o_grant  output  2  one-hot current owner; 2'b00 when no owner.

Function
REQ-016 SHALL implement states IDLE, BUSY, ABORT; registered grant index g and last-owner pointer lp.
REQ-017 IDLE: all wb_* outputs 0; if exactly one mN_cyc high, grant N; if both, grant the master != lp; next state BUSY; lp <= granted index.
REQ-018 Grant latency SHALL be exactly one cycle: mN_cyc sampled high at edge k gives wb_cyc high after edge k.
REQ-019 BUSY: wb_cyc, wb_stb, wb_we, wb_adr, wb_o_dat, wb_sel SHALL combinationally follow master g.
REQ-020 BUSY: mg_ack = wb_ack, mg_err = wb_err, combinational; the non-granted master's ack/err SHALL be 0.
REQ-021 wb_i_dat SHALL drive both m0_i_dat and m1_i_dat unconditionally.
REQ-022 BUSY -> IDLE when mg_cyc is sampled low; ownership held across any number of transfers while mg_cyc stays high.
REQ-023 One IDLE cycle SHALL separate consecutive grants; the same master is regranted if the other is not requesting.
REQ-024 8-bit stall counter: cleared in IDLE, on wb_ack, on wb_err, or when wb_stb low; otherwise increments in BUSY, saturating at 255.
REQ-025 When TIMEOUT != 0 and counter == TIMEOUT with no wb_ack/wb_err in that cycle: mg_err = 1 for that single cycle, next state ABORT.
REQ-026 wb_ack or wb_err in the timeout cycle SHALL take priority; no timeout error is raised.
REQ-027 ABORT: wb_cyc = wb_stb = 0, mN_ack = mN_err = 0; ABORT -> IDLE when mg_cyc sampled low.
REQ-028 Master dropping cyc mid-stall SHALL return to IDLE with no error.
REQ-029 o_grant SHALL be one-hot of g in BUSY and ABORT, 2'b00 in IDLE.

Reset
REQ-030 On i_rst high, asynchronously: state IDLE, g = 0, lp = 1 (m0 wins the first tie), counter = 0; all outputs 0 except m0_i_dat/m1_i_dat = wb_i_dat.
REQ-031 Reset asserted mid-transfer SHALL drop wb_cyc/wb_stb immediately and emit no ack/err to either master.

Verification
REQ-032 Both cyc rise same cycle after reset -> m0 granted (o_grant=01); after m0 drops cyc, m1 granted (10) one IDLE cycle later.
REQ-033 m1 holds cyc for 3 stb/ack transfers while m0 requests -> m0 sees no ack; o_grant stays 10 until m1_cyc low.
REQ-034 Read: m0_adr=0x0040, slave returns wb_i_dat=0xBEEF with wb_ack -> m0_ack=1, m0_i_dat=0xBEEF, m1_ack=0.
REQ-035 TIMEOUT=4, slave never acks -> m0_err pulses once when the counter reaches 4 (fifth stall cycle), wb_cyc=0 in ABORT, IDLE after m0_cyc low.
REQ-036 TIMEOUT=4, wb_ack arrives on the counter==4 cycle -> m0_ack=1, m0_err=0, state stays BUSY.
REQ-037 i_rst pulsed during BUSY -> wb_cyc=0 immediately; after release with both requesting, m0 granted.
